// File: rtl/s2p_multi.sv
// ---------------------------------------------------------------------------
// s2p_multi
//
// Multi-lane serial-to-parallel converter. LANES serial lanes are shifted in
// lock-step into frames of 1..DW bits. The frame length and the bit order are
// captured when a frame starts. A completed frame is moved into a one-deep
// output buffer. If the buffer is still occupied, the frame is dropped.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   s2p_start         start a frame (looked at in IDLE only)
//   s2p_abort         drop the frame in progress (looked at in SHIFT only)
//   cfg_len           frame length; 0 or >DW means DW
//   cfg_msb_first     1: first bit is the MSB, 0: first bit is the LSB
//   serial_vld        qualifies serial_din this cycle
//   serial_din        one bit per lane
//   parallel_dout     lane i is at [i*DW +: DW], right-justified
//   dout_vld/dout_rdy output buffer handshake
//   s2p_busy          high while in SHIFT (this is the FSM state)
//   s2p_done          1-cycle pulse when a frame is loaded into the buffer
//   s2p_ovf           1-cycle pulse when a completed frame is dropped
//
// Handshake: a frame transfers at any rising edge where dout_vld && dout_rdy.
// While dout_vld is high and dout_rdy is low, parallel_dout is held stable.
// ---------------------------------------------------------------------------
module s2p_multi #(
  parameter int DW    = 22,
  parameter int LANES = 1,
  parameter int CW    = $clog2(DW + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s2p_start,
  input  logic                  s2p_abort,
  input  logic [CW-1:0]         cfg_len,
  input  logic                  cfg_msb_first,
  input  logic                  serial_vld,
  input  logic [LANES-1:0]      serial_din,
  output logic [LANES*DW-1:0]   parallel_dout,
  output logic                  dout_vld,
  input  logic                  dout_rdy,
  output logic                  s2p_busy,
  output logic                  s2p_done,
  output logic                  s2p_ovf
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [CW-1:0] DW_C = CW'(DW);

  state_t                     state_q, state_d;
  logic [CW-1:0]              len_q, len_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       msb_q, msb_d;
  logic [LANES-1:0][DW-1:0]   sh_q, sh_d, sh_nxt;
  logic [LANES*DW-1:0]        dout_q, dout_d;
  logic                       vld_q, vld_d;
  logic                       done_q, done_d;
  logic                       ovf_q, ovf_d;
  logic                       last_bit;

  // Shift registers after absorbing the current bit. Each register is cleared
  // at start, so MSB-first shifting leaves the frame right-justified. LSB-first
  // writes bit cnt directly.
  always_comb begin
    sh_nxt = sh_q;
    for (int i = 0; i < LANES; i++) begin
      if (msb_q) begin
        sh_nxt[i] = {sh_q[i][DW-2:0], serial_din[i]};
      end else begin
        sh_nxt[i][cnt_q] = serial_din[i];
      end
    end
  end

  // The completing bit is the sampled bit taken when cnt == len-1.
  // len_q is never 0, so len_q - 1 does not wrap.
  assign last_bit = (state_q == SHIFT) && serial_vld && !s2p_abort &&
                    (cnt_q == len_q - 1'b1);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    msb_d   = msb_q;
    sh_d    = sh_q;
    dout_d  = dout_q;
    vld_d   = vld_q;
    done_d  = 1'b0;
    ovf_d   = 1'b0;

    // Consumption happens first. A frame that loads at the same edge
    // re-asserts vld below.
    if (vld_q && dout_rdy) begin
      vld_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (s2p_start) begin
          len_d   = ((cfg_len == '0) || (cfg_len > DW_C)) ? DW_C : cfg_len;
          msb_d   = cfg_msb_first;
          sh_d    = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (s2p_abort) begin
          state_d = IDLE;
        end else if (serial_vld) begin
          sh_d  = sh_nxt;
          cnt_d = cnt_q + 1'b1;
          if (last_bit) begin
            state_d = IDLE;
            if (!vld_q || dout_rdy) begin
              dout_d = sh_nxt;
              vld_d  = 1'b1;
              done_d = 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= DW_C;
      cnt_q   <= '0;
      msb_q   <= 1'b0;
      sh_q    <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      msb_q   <= msb_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign parallel_dout = dout_q;
  assign dout_vld      = vld_q;
  assign s2p_busy      = (state_q == SHIFT);
  assign s2p_done      = done_q;
  assign s2p_ovf       = ovf_q;

endmodule

// File: tb/tb_s2p_multi.sv
// ---------------------------------------------------------------------------
// tb_s2p_multi
//
// Directed bench for s2p_multi with DW=22 and LANES=4. In the single-lane
// scenarios, every lane carries the same bit stream, so each expected word is
// the lane word replicated four times. The lane-slicing scenario gives each
// lane its own word.
// ---------------------------------------------------------------------------
module tb_s2p_multi;

  localparam int DW    = 22;
  localparam int LANES = 4;
  localparam int CW    = $clog2(DW + 1);
  localparam int W     = LANES * DW;

  logic              clk;
  logic              rst_n;
  logic              s2p_start;
  logic              s2p_abort;
  logic [CW-1:0]     cfg_len;
  logic              cfg_msb_first;
  logic              serial_vld;
  logic [LANES-1:0]  serial_din;
  logic [W-1:0]      parallel_dout;
  logic              dout_vld;
  logic              dout_rdy;
  logic              s2p_busy;
  logic              s2p_done;
  logic              s2p_ovf;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  s2p_multi #(.DW(DW), .LANES(LANES)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s2p_start     (s2p_start),
    .s2p_abort     (s2p_abort),
    .cfg_len       (cfg_len),
    .cfg_msb_first (cfg_msb_first),
    .serial_vld    (serial_vld),
    .serial_din    (serial_din),
    .parallel_dout (parallel_dout),
    .dout_vld      (dout_vld),
    .dout_rdy      (dout_rdy),
    .s2p_busy      (s2p_busy),
    .s2p_done      (s2p_done),
    .s2p_ovf       (s2p_ovf)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (actual running, required finished)");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_dout(input string tag);
    logic [W-1:0] exp;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, actual 0x%0h", tag, parallel_dout);
    end else begin
      exp = exp_q.pop_front();
      check(tag, parallel_dout, exp);
    end
  endtask

  function automatic logic [W-1:0] rep(input logic [DW-1:0] x);
    return {LANES{x}};
  endfunction

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge. Outputs are sampled at
  // the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a frame. The cfg inputs are then changed to junk to show that
  // they are latched.
  task automatic start_frame(input logic [CW-1:0] len, input logic msb);
    s2p_start     = 1'b1;
    cfg_len       = len;
    cfg_msb_first = msb;
    serial_din    = LANES'($urandom);
    tick();
    s2p_start     = 1'b0;
    cfg_len       = CW'(3);
    cfg_msb_first = ~msb;
  endtask

  task automatic drive_bit(input int len, input logic msb, input int k, input logic [W-1:0] data);
    serial_vld = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      serial_din[i] = data[i*DW + (msb ? (len - 1 - k) : k)];
    end
  endtask

  task automatic shift_bits(input int len, input logic msb, input int from, input int upto,
                            input logic [W-1:0] data);
    for (int k = from; k < upto; k++) begin
      drive_bit(len, msb, k, data);
      tick();
    end
    serial_vld = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] lane_data;
  logic [5:0]   vld_pat;
  int           kk;

  initial begin
    rst_n         = 1'b0;
    s2p_start     = 1'b0;
    s2p_abort     = 1'b0;
    cfg_len       = '0;
    cfg_msb_first = 1'b0;
    serial_vld    = 1'b0;
    serial_din    = '0;
    dout_rdy      = 1'b1;
    repeat (3) tick();
    check("rst_dout", parallel_dout, '0);
    check("rst_vld", W'(dout_vld), '0);
    check("rst_busy", W'(s2p_busy), '0);
    check("rst_done_ovf", W'({s2p_done, s2p_ovf}), '0);
    rst_n = 1'b1;
    tick();

    // 1) cfg_len=0 means 22 bits, MSB-first, 22'h2AAAAA
    start_frame('0, 1'b1);
    check("t1_busy", W'(s2p_busy), W'(1));
    shift_bits(22, 1'b1, 0, 21, rep(22'h2AAAAA));
    check("t1_vld_before_last", W'(dout_vld), '0);
    exp_q.push_back(rep(22'h2AAAAA));
    shift_bits(22, 1'b1, 21, 22, rep(22'h2AAAAA));
    check("t1_vld", W'(dout_vld), W'(1));
    check("t1_done", W'(s2p_done), W'(1));
    check("t1_busy_low", W'(s2p_busy), '0);
    check_dout("t1_dout");
    tick();
    check("t1_done_width", W'(s2p_done), '0);
    check("t1_consumed", W'(dout_vld), '0);

    // 2) len 8, LSB-first, bits 1,0,1,1,0,0,0,0 -> 0x0D
    start_frame(CW'(8), 1'b0);
    exp_q.push_back(rep(22'h00000D));
    shift_bits(8, 1'b0, 0, 8, rep(22'h00000D));
    check_dout("t2_dout");
    tick();

    // 3) len 4, MSB-first 4'hA, vld pattern 1,0,1,1,0,1
    start_frame(CW'(4), 1'b1);
    vld_pat = 6'b101101;   // bit 5 is the first cycle
    kk = 0;
    for (int c = 0; c < 6; c++) begin
      if (vld_pat[5-c]) begin
        drive_bit(4, 1'b1, kk, rep(22'hA));
        kk++;
      end else begin
        serial_vld = 1'b0;
        serial_din = LANES'($urandom);
      end
      if (c == 5) begin
        exp_q.push_back(rep(22'hA));
      end
      tick();
      if (c == 4) begin
        check("t3_busy_mid", W'(s2p_busy), W'(1));
        check("t3_vld_mid", W'(dout_vld), '0);
      end
    end
    serial_vld = 1'b0;
    check("t3_busy_end", W'(s2p_busy), '0);
    check_dout("t3_dout");
    tick();

    // 4) overflow: rdy low, 0x11 kept, 0x22 dropped; 0x33 loads while rdy
    dout_rdy = 1'b0;
    start_frame(CW'(8), 1'b1);
    shift_bits(8, 1'b1, 0, 8, rep(22'h11));
    check("t4_first", parallel_dout, rep(22'h11));
    tick();
    start_frame(CW'(8), 1'b1);
    shift_bits(8, 1'b1, 0, 8, rep(22'h22));
    check("t4_ovf", W'(s2p_ovf), W'(1));
    check("t4_no_done", W'(s2p_done), '0);
    check("t4_held", parallel_dout, rep(22'h11));
    check("t4_vld_held", W'(dout_vld), W'(1));
    tick();
    check("t4_ovf_width", W'(s2p_ovf), '0);
    start_frame(CW'(8), 1'b1);
    shift_bits(8, 1'b1, 0, 7, rep(22'h33));
    dout_rdy = 1'b1;
    exp_q.push_back(rep(22'h33));
    shift_bits(8, 1'b1, 7, 8, rep(22'h33));
    check_dout("t4_third");
    check("t4_vld_stays", W'(dout_vld), W'(1));
    check("t4_done3", W'(s2p_done), W'(1));
    tick();
    check("t4_drained", W'(dout_vld), '0);

    // 5) abort after 5 of 8 bits, then a clean frame 0x5C, then abort on the last bit
    start_frame(CW'(8), 1'b1);
    shift_bits(8, 1'b1, 0, 5, rep(22'hFF));
    drive_bit(8, 1'b1, 5, rep(22'hFF));
    s2p_abort = 1'b1;
    tick();
    s2p_abort  = 1'b0;
    serial_vld = 1'b0;
    check("t5_busy_drop", W'(s2p_busy), '0);
    check("t5_no_flags", W'({dout_vld, s2p_done, s2p_ovf}), '0);
    s2p_abort = 1'b1;   // in IDLE this must be ignored
    start_frame(CW'(8), 1'b1);
    s2p_abort = 1'b0;
    check("t5_idle_abort_ignored", W'(s2p_busy), W'(1));
    exp_q.push_back(rep(22'h5C));
    shift_bits(8, 1'b1, 0, 8, rep(22'h5C));
    check_dout("t5_dout");
    tick();
    start_frame(CW'(8), 1'b1);
    shift_bits(8, 1'b1, 0, 7, rep(22'h77));
    drive_bit(8, 1'b1, 7, rep(22'h77));
    s2p_abort = 1'b1;
    tick();
    s2p_abort  = 1'b0;
    serial_vld = 1'b0;
    check("t5_abort_last", W'({dout_vld, s2p_done, s2p_ovf, s2p_busy}), '0);

    // 6) four lanes with distinct words
    lane_data = {22'h2AAAAA, 22'h155555, 22'h000000, 22'h3FFFFF};
    dout_rdy  = 1'b0;
    start_frame(CW'(22), 1'b1);
    exp_q.push_back(lane_data);
    shift_bits(22, 1'b1, 0, 22, lane_data);
    check_dout("t6_lanes");
    dout_rdy = 1'b1;
    tick();
    dout_rdy = 1'b0;
    check("t6_drained", W'(dout_vld), '0);

    // Load a frame, then pulse reset 10 bits into the next one
    start_frame(CW'(22), 1'b1);
    shift_bits(22, 1'b1, 0, 22, lane_data);
    check("t6_loaded", parallel_dout, lane_data);
    start_frame(CW'(22), 1'b1);
    shift_bits(22, 1'b1, 0, 10, lane_data);
    rst_n = 1'b0;
    #1;
    check("t6_rst_dout", parallel_dout, '0);
    check("t6_rst_flags", W'({dout_vld, s2p_busy, s2p_done, s2p_ovf}), '0);
    tick();
    rst_n = 1'b1;
    tick();
    start_frame(CW'(22), 1'b0);
    exp_q.push_back(lane_data);
    shift_bits(22, 1'b0, 0, 22, lane_data);
    check_dout("t6_clean_after_rst");
    check("t6_done_after_rst", W'(s2p_done), W'(1));
    tick();

    check("scoreboard_empty", W'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/s2p_multi.md
Name: s2p_multi

Overview:
- Next-generation serial-to-parallel converter. Deserialises LANES independent serial lanes in lock-step into frames of runtime-programmable length (1..DW bits).
- Supports MSB-first or LSB-first ordering, input bit qualification (serial_vld), abort, and a one-deep output buffer with valid/ready handshake and overflow reporting.
- Sits between serial front-ends (ADC/SPI-style receivers) and word-oriented downstream logic.

Parameters:
- DW, 22, maximum frame length in bits per lane; parallel word width per lane.
- LANES, 1, number of serial lanes captured in parallel (>=1).
- CW, $clog2(DW+1), width of cfg_len and of the internal bit counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- s2p_start  input  1  start-of-frame request; sampled in IDLE only.
- s2p_abort  input  1  discard the frame in progress; sampled in SHIFT only.
- cfg_len  input  CW  frame length; latched at start.
- cfg_msb_first  input  1  1 = first bit is MSB, 0 = first bit is LSB; latched at start.
- serial_vld  input  1  qualifies serial_din this cycle.
- serial_din  input  LANES  one bit per lane.
- parallel_dout  output  LANES*DW  lane i occupies bits [i*DW +: DW].
- dout_vld  output  1  parallel_dout holds an unconsumed frame.
- dout_rdy  input  1  downstream accepts the frame when dout_vld && dout_rdy at a clock edge.
- s2p_busy  output  1  high while in SHIFT.
- s2p_done  output  1  one-cycle pulse when a frame is loaded into the output buffer.
- s2p_ovf  output  1  one-cycle pulse when a completed frame is dropped.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE. Counter, shift registers, parallel_dout, dout_vld, s2p_busy, s2p_done and s2p_ovf are all 0.
- States: IDLE, SHIFT. s2p_busy = (state == SHIFT).
- IDLE, on s2p_start = 1:
  - Latch len = (cfg_len == 0 || cfg_len > DW) ? DW : cfg_len.
  - Latch cfg_msb_first.
  - Clear all lane shift registers, set cnt = 0, go to SHIFT.
  - serial_din is not sampled in the start cycle.
- SHIFT, each cycle with serial_vld = 1 and s2p_abort = 0, for every lane:
  - MSB-first: reg <= {reg[DW-2:0], din}.
  - LSB-first: reg[cnt] <= din.
  - In both modes the result is right-justified: first bit lands at bit len-1 (MSB-first) or bit 0 (LSB-first). Bits [DW-1:len] are 0.
  - cnt increments.
- serial_vld = 0 in SHIFT: no sample, no count change, stay in SHIFT.
- Frame completion is the sampled cycle with cnt == len-1. The assembled word, including the current bit, is used directly. At that edge:
  - Output slot free (dout_vld == 0, or dout_rdy == 1): load parallel_dout, dout_vld <= 1, s2p_done pulses next cycle.
  - Output slot occupied (dout_vld == 1 and dout_rdy == 0): frame dropped, parallel_dout unchanged, s2p_ovf pulses next cycle.
  - Either way, state returns to IDLE.
- Latency: dout_vld/s2p_done rise the cycle after the last bit is sampled.
- Throughput: s2p_start is accepted in the first IDLE cycle, so the minimum frame period is len+1 cycles with continuous serial_vld.
- Output buffer:
  - dout_vld clears on dout_vld && dout_rdy unless a new frame loads at the same edge; in that case dout_vld stays 1 with the new data.
  - parallel_dout is stable while dout_vld && !dout_rdy.
- s2p_abort in SHIFT:
  - Return to IDLE, discard the partial frame; no done, no ovf.
  - Abort has priority over a completing bit in the same cycle.
  - Output buffer is unaffected.
  - s2p_abort in IDLE is ignored.
- s2p_start in SHIFT is ignored; cfg_len and cfg_msb_first changes mid-frame have no effect.
- Reset mid-frame: immediate return to reset values, including any unconsumed output.

Test Plan:
- DW=22, LANES=1, cfg_len=0, msb_first=1, continuous vld, bits of 22'h2AAAAA MSB first -> dout=22'h2AAAAA; dout_vld and s2p_done high one cycle after the 22nd bit; done width 1 cycle.
- cfg_len=8, msb_first=0, bits 1,0,1,1,0,0,0,0 -> dout=22'h00000D; bits [21:8]=0.
- cfg_len=4, msb_first=1, bits 1,0,1,0 with vld pattern 1,0,1,1,0,1 (din toggled randomly while vld=0) -> dout=4'hA; busy high until the 4th valid bit.
- dout_rdy=0, two frames 8'h11 then 8'h22 (len=8) -> dout holds 8'h11, s2p_ovf pulses once. Then third frame 8'h33 completes with dout_rdy=1 at that edge -> dout=8'h33, dout_vld stays 1.
- Abort after 5 of 8 bits -> busy drops next cycle, no done/ovf. Following frame 8'h5C -> dout=8'h5C. Abort coinciding with the 8th bit -> no output.
- LANES=4, len=22, lanes fed 22'h3FFFFF, 0, 22'h155555, 22'h2AAAAA -> correct lane slicing. Repeat with rst_n pulsed low at bit 10 -> all outputs 0 immediately; next frame is clean.
